// File: rtl/tone_detect.sv
// rtl/tone_detect.sv - recognises note and octave from a signed PCM stream via zero-crossing period
module tone_detect #(
   parameter int clk_mhz        = 50,
   parameter int y_width        = 16,
   parameter int note_width     = 4,
   parameter int sample_rate_hz = 48828,
   parameter int hyst           = 512,
   parameter int stable         = 3,
   parameter int period_width   = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sample_valid,
   input  logic signed [y_width-1:0] sample,
   output logic [note_width-1:0]     note,
   output logic [2:0]                octave,
   output logic                      note_valid,
   output logic [period_width-1:0]   period
);

   typedef enum logic [1:0] {IDLE, NORM, MATCH, FILTER} state_t;

   // Equal-tempered C3..B3 in Hz; periods in samples are derived from the strobe rate.
   function automatic int tone_period(input int i);
      real f;
      case (i)
         0:       f = 130.8128;
         1:       f = 138.5913;
         2:       f = 146.8324;
         3:       f = 155.5635;
         4:       f = 164.8138;
         5:       f = 174.6141;
         6:       f = 184.9972;
         7:       f = 195.9977;
         8:       f = 207.6523;
         9:       f = 220.0000;
         10:      f = 233.0819;
         default: f = 246.9417;
      endcase
      return $rtoi(real'(sample_rate_hz) / f);
   endfunction

   localparam logic [period_width-1:0] t_tab [0:11] = '{
      period_width'(tone_period(0)),  period_width'(tone_period(1)),
      period_width'(tone_period(2)),  period_width'(tone_period(3)),
      period_width'(tone_period(4)),  period_width'(tone_period(5)),
      period_width'(tone_period(6)),  period_width'(tone_period(7)),
      period_width'(tone_period(8)),  period_width'(tone_period(9)),
      period_width'(tone_period(10)), period_width'(tone_period(11))};

   // Folding window sits a quarter tone below B3 and spans exactly one octave.
   localparam int                      lo_int    = $rtoi(real'(tone_period(11)) * 0.9715);
   localparam logic [period_width-1:0] lo        = period_width'(lo_int);
   localparam logic [period_width-1:0] hi        = period_width'(2 * lo_int);
   localparam logic [period_width-1:0] cnt_max   = {period_width{1'b1}};
   localparam logic [note_width-1:0]   note_none = note_width'(12);
   localparam int                      run_w     = $clog2(stable + 1);
   localparam logic signed [y_width-1:0] hyst_pos = y_width'(hyst);
   localparam logic signed [y_width-1:0] hyst_neg = -hyst_pos;

   // Sample strobes must be spaced wider than the ~20-cycle estimate pipeline.
   localparam int clk_per_sample = (clk_mhz * 1000000) / sample_rate_hz;
   if (clk_per_sample < 20) begin : g_strobe_spacing_too_tight
   end

   state_t                  state_q, state_d;
   logic                    armed_q, armed_d;
   logic [period_width-1:0] cnt_q, cnt_d;
   logic [period_width-1:0] period_q, period_d;
   logic [period_width-1:0] n_q, n_d;
   logic [2:0]              k_q, k_d;
   logic [3:0]              idx_q, idx_d;
   logic [period_width-1:0] best_diff_q, best_diff_d;
   logic [3:0]              best_idx_q, best_idx_d;
   logic                    est_none_q, est_none_d;
   logic [note_width-1:0]   prev_note_q, prev_note_d;
   logic [2:0]              prev_oct_q, prev_oct_d;
   logic [run_w-1:0]        run_q, run_d;
   logic [note_width-1:0]   note_q, note_d;
   logic [2:0]              octave_q, octave_d;
   logic                    note_valid_q, note_valid_d;

   logic                    crossing, timeout;
   logic [period_width-1:0] p_val, tab_val, diff;
   logic [note_width-1:0]   est_note;
   logic [2:0]              est_oct;
   logic [run_w-1:0]        run_next;

   // Hysteretic rising zero-crossing detector and saturating period counter.
   always_comb begin
      armed_d  = armed_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      crossing = 1'b0;
      timeout  = 1'b0;
      p_val    = cnt_q;
      if (sample_valid) begin
         if (armed_q && sample >= hyst_pos) begin
            crossing = 1'b1;
            armed_d  = 1'b0;
            p_val    = (cnt_q == cnt_max) ? cnt_max : cnt_q + 1'b1;
            period_d = p_val;
            cnt_d    = '0;
         end else begin
            if (sample <= hyst_neg) armed_d = 1'b1;
            if (cnt_q != cnt_max) begin
               cnt_d   = cnt_q + 1'b1;
               timeout = (cnt_q == cnt_max - 1'b1);
            end
         end
      end
   end

   // Estimate pipeline (fold, table match, stability filter) plus silence timeout.
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      k_d          = k_q;
      idx_d        = idx_q;
      best_diff_d  = best_diff_q;
      best_idx_d   = best_idx_q;
      est_none_d   = est_none_q;
      prev_note_d  = prev_note_q;
      prev_oct_d   = prev_oct_q;
      run_d        = run_q;
      note_d       = note_q;
      octave_d     = octave_q;
      note_valid_d = note_valid_q;
      tab_val      = t_tab[idx_q];
      diff         = (n_q >= tab_val) ? n_q - tab_val : tab_val - n_q;
      est_note     = est_none_q ? note_none : note_width'(best_idx_q);
      est_oct      = est_none_q ? 3'd0 : k_q;
      run_next     = ((est_note == prev_note_q) && (est_oct == prev_oct_q)) ?
                     ((run_q == run_w'(stable)) ? run_q : run_q + 1'b1) : run_w'(1);
      case (state_q)
         IDLE: begin
            if (crossing) begin
               n_d     = p_val;
               k_d     = 3'd0;
               state_d = NORM;
            end
         end
         NORM: begin
            if (k_q == 3'd0 && n_q >= hi) begin
               est_none_d = 1'b1;
               state_d    = FILTER;
            end else if (n_q >= lo) begin
               est_none_d = 1'b0;
               idx_d      = 4'd0;
               state_d    = MATCH;
            end else if (k_q == 3'd5) begin
               est_none_d = 1'b1;
               state_d    = FILTER;
            end else begin
               n_d = {n_q[period_width-2:0], 1'b0};
               k_d = k_q + 3'd1;
            end
         end
         MATCH: begin
            if (idx_q == 4'd0 || diff < best_diff_q) begin
               best_diff_d = diff;
               best_idx_d  = idx_q;
            end
            if (idx_q == 4'd11) state_d = FILTER;
            else                idx_d   = idx_q + 4'd1;
         end
         FILTER: begin
            prev_note_d = est_note;
            prev_oct_d  = est_oct;
            run_d       = run_next;
            if (run_next == run_w'(stable)) begin
               note_d       = est_note;
               octave_d     = est_oct;
               note_valid_d = !est_none_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (timeout) begin
         note_d       = note_none;
         note_valid_d = 1'b0;
         prev_note_d  = note_none;
         prev_oct_d   = 3'd0;
         run_d        = '0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         armed_q      <= 1'b0;
         cnt_q        <= '0;
         period_q     <= '0;
         n_q          <= '0;
         k_q          <= '0;
         idx_q        <= '0;
         best_diff_q  <= '0;
         best_idx_q   <= '0;
         est_none_q   <= 1'b0;
         prev_note_q  <= note_none;
         prev_oct_q   <= '0;
         run_q        <= '0;
         note_q       <= note_none;
         octave_q     <= '0;
         note_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         cnt_q        <= cnt_d;
         period_q     <= period_d;
         n_q          <= n_d;
         k_q          <= k_d;
         idx_q        <= idx_d;
         best_diff_q  <= best_diff_d;
         best_idx_q   <= best_idx_d;
         est_none_q   <= est_none_d;
         prev_note_q  <= prev_note_d;
         prev_oct_q   <= prev_oct_d;
         run_q        <= run_d;
         note_q       <= note_d;
         octave_q     <= octave_d;
         note_valid_q <= note_valid_d;
      end
   end

   assign note       = note_q;
   assign octave     = octave_q;
   assign note_valid = note_valid_q;
   assign period     = period_q;

endmodule
